mem_port_arbiter: RTL

Shares the single instruction/data memory port between the instruction-fetch queue (read-only requester) and the load/store unit (read/write requester). Arbitrates, forwards one transaction at a time to memory, and routes the response back to its owner. Data has priority over fetch, bounded by a fetch-starvation limit. Sits between the fetch queue / LSU and the memory model or cache.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch queue and the
// load/store unit. Data requests win over fetch until fetch has watched
// STARVE_LIMIT consecutive data grants, then fetch is forced ahead. Exactly
// one transaction is outstanding; the response is routed back to its owner.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_resp_valid,
  output logic [ADDR_WIDTH-1:0] i_resp_addr,
  output logic [DATA_WIDTH-1:0] i_resp_inst,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_wen,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_resp_valid,
  output logic [DATA_WIDTH-1:0] d_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  logic [3:0]              starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0]   i_addr_q, i_addr_d;
  logic                    grant_d, grant_i;

  // Count of data grants taken while fetch waited, clamped at the limit.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
  endfunction

  // State, starvation counter and accepted fetch address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      i_addr_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      i_addr_q     <= i_addr_d;
    end
  end

  // Grant selection, request mux, response routing and next state.
  // Everything is forced quiet while reset is held so outputs drop at once.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    i_addr_d      = i_addr_q;
    grant_d       = 1'b0;
    grant_i       = 1'b0;
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    i_resp_valid  = 1'b0;
    i_resp_inst   = '0;
    d_resp_valid  = 1'b0;
    d_resp_rdata  = '0;
    i_resp_addr   = i_addr_q;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (d_req_valid && !(i_req_valid && starve_cnt_q == LIMIT)) begin
            grant_d = 1'b1;
          end else if (i_req_valid) begin
            grant_i = 1'b1;
          end
          mem_req_valid = grant_d | grant_i;
          if (grant_d) begin
            mem_req_addr  = d_req_addr;
            mem_req_wen   = d_req_wen;
            mem_req_wdata = d_req_wdata;
            d_req_ready   = mem_req_ready;
            if (mem_req_ready) begin
              state_d      = WAIT_D;
              starve_cnt_d = i_req_valid ? sat_inc(starve_cnt_q) : 4'd0;
            end
          end else if (grant_i) begin
            mem_req_addr = i_req_addr;
            i_req_ready  = mem_req_ready;
            if (mem_req_ready) begin
              state_d      = WAIT_I;
              i_addr_d     = i_req_addr;
              starve_cnt_d = 4'd0;
            end
          end
        end
        WAIT_I: begin
          if (mem_resp_valid) begin
            i_resp_valid = 1'b1;
            i_resp_inst  = mem_resp_rdata;
            state_d      = IDLE;
          end
        end
        WAIT_D: begin
          if (mem_resp_valid) begin
            d_resp_valid = 1'b1;
            d_resp_rdata = mem_resp_rdata;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
